// File: rtl/vga_top.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vga_top : 640x480@60 VGA sync generator with a two-colour checkerboard.
// Optional macro COLOUR_CYCLE_EN: the FG tile colour steps by one per frame.
// Rev 1.0
// -----------------------------------------------------------------------------
module vga_top #(
  parameter int         CLK_DIV   = 4,
  parameter int         H_VISIBLE = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_VISIBLE = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter int         TILE_LOG2 = 4,
  parameter logic [7:0] FG_COLOUR = 8'hFF,
  parameter logic [7:0] BG_COLOUR = 8'h03
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_COLOUR
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST       = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_VIS_END    = H_W'(H_VISIBLE);
  localparam logic [V_W-1:0]   V_VIS_END    = V_W'(V_VISIBLE);
  localparam logic [H_W-1:0]   H_SYNC_FIRST = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0]   H_SYNC_LAST  = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_SYNC_FIRST = V_W'(V_VISIBLE + V_FP);
  localparam logic [V_W-1:0]   V_SYNC_LAST  = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   hcount_q, hcount_d;
  logic [V_W-1:0]   vcount_q, vcount_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [7:0]       colour_q, colour_d;

  logic             pix_en;
  logic             h_wrap;
  logic             v_wrap;
  logic             in_visible;
  logic             tile_sel;
  logic [7:0]       fg_colour;

  assign pix_en     = (div_q == DIV_LAST);
  assign h_wrap     = (hcount_q == H_LAST);
  assign v_wrap     = (vcount_q == V_LAST);
  assign in_visible = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
  assign tile_sel   = hcount_q[TILE_LOG2] ^ vcount_q[TILE_LOG2];

  always_comb begin
    div_d = pix_en ? '0 : div_q + DIV_W'(1);
  end

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      hcount_d = h_wrap ? '0 : hcount_q + H_W'(1);
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + V_W'(1);
      end
    end
  end

  // Outputs are computed from the current counters, so they lag them by one pixel.
  always_comb begin
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    if (pix_en) begin
      hs_d     = !((hcount_q >= H_SYNC_FIRST) && (hcount_q <= H_SYNC_LAST));
      vs_d     = !((vcount_q >= V_SYNC_FIRST) && (vcount_q <= V_SYNC_LAST));
      colour_d = in_visible ? (tile_sel ? fg_colour : BG_COLOUR) : 8'h00;
    end
  end

`ifdef COLOUR_CYCLE_EN
  logic [7:0] fg_q, fg_d;

  always_comb begin
    fg_d = fg_q;
    if (pix_en && h_wrap && v_wrap) begin
      fg_d = fg_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fg_q <= FG_COLOUR;
    end else begin
      fg_q <= fg_d;
    end
  end

  assign fg_colour = fg_q;
`else
  assign fg_colour = FG_COLOUR;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= 8'h00;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
    end
  end

  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_COLOUR = colour_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_top.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vga_top : scoreboard bench for vga_top using a reduced timing geometry.
// Rev 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_top;

  localparam int         CLK_DIV   = 4;
  localparam int         H_VISIBLE = 40;
  localparam int         H_FP      = 4;
  localparam int         H_SYNC    = 6;
  localparam int         H_BP      = 6;
  localparam int         V_VISIBLE = 24;
  localparam int         V_FP      = 2;
  localparam int         V_SYNC    = 2;
  localparam int         V_BP      = 4;
  localparam int         TILE_LOG2 = 3;
  localparam logic [7:0] FG        = 8'hFF;
  localparam logic [7:0] BG        = 8'h03;

  localparam int HT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT * CLK_DIV;
  localparam logic [9:0] RST_VAL = {1'b1, 1'b1, 8'h00};

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [7:0] VGA_COLOUR;

  vga_top #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .TILE_LOG2(TILE_LOG2), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_COLOUR(VGA_COLOUR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input int idx);
    int h, v, f;
    logic hs, vs;
    logic [7:0] fg, col;
    h  = idx % HT;
    v  = (idx / HT) % VT;
    f  = idx / (HT * VT);
    hs = !(h >= H_VISIBLE + H_FP && h < H_VISIBLE + H_FP + H_SYNC);
    vs = !(v >= V_VISIBLE + V_FP && v < V_VISIBLE + V_FP + V_SYNC);
`ifdef COLOUR_CYCLE_EN
    fg = FG + 8'(f);
`else
    fg = FG;
    if (f < 0) fg = 8'h00;
`endif
    if (h < H_VISIBLE && v < V_VISIBLE)
      col = (((h >> TILE_LOG2) ^ (v >> TILE_LOG2)) & 1) != 0 ? fg : BG;
    else
      col = 8'h00;
    return {hs, vs, col};
  endfunction

  // Reference model: predicts the outputs after every rising edge.
  logic [9:0] sb_q[$];
  logic [9:0] exp_now = RST_VAL;
  int         n_rel   = 0;
  int         cur_idx = -1;

  initial forever begin
    @(posedge CLK);
    if (!RESET) begin
      n_rel   = 0;
      cur_idx = -1;
      exp_now = RST_VAL;
    end else begin
      n_rel++;
      if (n_rel % CLK_DIV == 0) begin
        cur_idx = n_rel / CLK_DIV - 1;
        exp_now = model(cur_idx);
      end
    end
    sb_q.push_back(exp_now);
  end

  // Monitor: compares on the falling edge and measures sync edges.
  int         cyc = 0;
  logic       prev_hs = 1'b1, prev_vs = 1'b1;
  int         hs_fall = -1, vs_fall = -1;
  int         hs_period = 0, hs_low = 0, vs_period = 0, vs_low = 0;
  int         rel_cyc = 0;
  bit         first_pending = 1'b0, vs_rel_pending = 1'b0;
  int         first_chg = 0, vs_rel = 0;
  logic [7:0] obs [HT*VT];

  initial forever begin
    logic [9:0] e;
    @(negedge CLK);
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("outputs", {22'd0, VGA_HS, VGA_VS, VGA_COLOUR}, {22'd0, e});
    end
    if (cur_idx >= 0 && cur_idx < HT * VT) obs[cur_idx] = VGA_COLOUR;
    if (first_pending && {VGA_HS, VGA_VS, VGA_COLOUR} != RST_VAL) begin
      first_chg     = cyc - rel_cyc;
      first_pending = 1'b0;
    end
    if (prev_hs && !VGA_HS) begin
      if (hs_fall >= 0) hs_period = cyc - hs_fall;
      hs_fall = cyc;
    end
    if (!prev_hs && VGA_HS) hs_low = cyc - hs_fall;
    if (prev_vs && !VGA_VS) begin
      if (vs_fall >= 0) vs_period = cyc - vs_fall;
      vs_fall = cyc;
      if (vs_rel_pending) begin
        vs_rel         = cyc - rel_cyc;
        vs_rel_pending = 1'b0;
      end
    end
    if (!prev_vs && VGA_VS) vs_low = cyc - vs_fall;
    prev_hs = VGA_HS;
    prev_vs = VGA_VS;
  end

  initial begin
    bit hit;
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check_eq("rst_hs", {31'd0, VGA_HS}, 32'd1);
    check_eq("rst_vs", {31'd0, VGA_VS}, 32'd1);
    check_eq("rst_colour", {24'd0, VGA_COLOUR}, 32'd0);
    #1;
    RESET          = 1'b1;
    rel_cyc        = cyc;
    first_pending  = 1'b1;
    vs_rel_pending = 1'b1;

    repeat (2 * FRAME + 200) @(negedge CLK);
    check_eq("first_change", first_chg, CLK_DIV);
    check_eq("hs_period", hs_period, HT * CLK_DIV);
    check_eq("hs_low", hs_low, H_SYNC * CLK_DIV);
    check_eq("vs_period", vs_period, FRAME);
    check_eq("vs_low", vs_low, V_SYNC * HT * CLK_DIV);
    check_eq("vs_after_release", vs_rel, ((V_VISIBLE + V_FP) * HT + 1) * CLK_DIV);
    check_eq("pix_0_0", {24'd0, obs[0]}, 32'h03);
    check_eq("pix_8_0", {24'd0, obs[8]}, 32'hFF);
    check_eq("pix_8_8", {24'd0, obs[8 * HT + 8]}, 32'h03);
    check_eq("pix_0_8", {24'd0, obs[8 * HT]}, 32'hFF);
    check_eq("pix_hblank_first", {24'd0, obs[H_VISIBLE]}, 32'h00);
    check_eq("pix_hblank_last", {24'd0, obs[HT - 1]}, 32'h00);
    check_eq("pix_vblank_first", {24'd0, obs[V_VISIBLE * HT]}, 32'h00);
    check_eq("pix_frame_last", {24'd0, obs[HT * VT - 1]}, 32'h00);

    // Mid-frame reset inside the visible area.
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge CLK);
      hit = (cur_idx % (HT * VT)) == (12 * HT + 20);
    end
    check_eq("midrst_reached", {31'd0, hit}, 32'd1);
    #1;
    RESET = 1'b0;
    #1;
    check_eq("midrst_hs", {31'd0, VGA_HS}, 32'd1);
    check_eq("midrst_vs", {31'd0, VGA_VS}, 32'd1);
    check_eq("midrst_colour", {24'd0, VGA_COLOUR}, 32'd0);
    repeat (3) @(negedge CLK);
    #1;
    RESET          = 1'b1;
    rel_cyc        = cyc;
    vs_rel_pending = 1'b1;
    vs_rel         = 0;

    repeat (3 * FRAME + 100) @(negedge CLK);
    check_eq("midrst_vs_after_release", vs_rel, ((V_VISIBLE + V_FP) * HT + 1) * CLK_DIV);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
